onehot_queue_ctrl: RTL and testbench
====================================

# onehot_queue_ctrl

- FIFO controller that sits directly upstream of the no-decode register RAM and supplies its one-hot read and write addresses.
- Keeps head and tail pointers as rotating one-hot registers, plus an occupancy count, so the RAM never needs an address decoder.
- Serves queue-style structures (load/store queue payload, issue payload, free lists): one enqueue port, one dequeue port, one flush.

## Interface
- DEPTH, 16: number of RAM entries and one-hot pointer width; must be at least 2.
- WIDTH, 32: payload width passed to the RAM write port.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.
- clkGated  in  1  clock (already decided).
- reset  in  1  synchronous, active-high (already decided).
- ramReady_i  in  1  RAM ready flag; while 0, no enqueue or dequeue is accepted.
- flush_i  in  1  empties the queue at the next edge.
- enq_i  in  1  enqueue request.
- enqData_i  in  WIDTH  enqueue payload.
- enqReady_o  out  1  enqueue is accepted this cycle.
- deq_i  in  1  dequeue request.
- deqValid_o  out  1  the head entry is valid.
- ramRdAddr_o  out  DEPTH  one-hot head pointer; drives RAM read-port address.
- ramWrAddr_o  out  DEPTH  one-hot tail pointer; drives RAM write-port address.
- ramWrData_o  out  WIDTH  equals enqData_i.
- ramWrEn_o  out  1  enqueue accepted.
- count_o  out  CNT_W  occupancy.
- full_o, empty_o  out  1 each  occupancy flags.
- ptrErr_o  out  1  sticky flag: a pointer was seen not one-hot.

## Operation
- enqReady_o = ramReady_i & ~full_o & ~flush_i.
- deqValid_o = ramReady_i & ~empty_o.
- Accepted enqueue = enq_i & enqReady_o.
  - ramWrEn_o = accepted enqueue, combinationally.
  - The RAM captures the write at the edge.
  - Tail rotates left by one position; bit DEPTH-1 wraps to bit 0.
- Accepted dequeue = deq_i & deqValid_o & ~flush_i.
  - Head rotates left by one with the same wrap.
  - Payload is read combinationally through ramRdAddr_o in the same cycle.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both occur or neither occurs.
- Flags:
  - full_o = (count_o == DEPTH).
  - empty_o = (count_o == 0).
  - Both are derived from the registered count.
- Full queue: enqueue is rejected even when a dequeue happens in the same cycle. There is no pass-through.
- Empty queue: deq_i is ignored. An entry enqueued this cycle is not dequeuable until the next cycle.
- Flush:
  - Next edge sets head = tail = one-hot bit 0 and count = 0.
  - Any enq_i/deq_i in the flush cycle is dropped; ramWrEn_o = 0.
  - RAM contents are left untouched.
- Priority: reset > flush > enqueue/dequeue.
- ptrErr_o:
  - Set when head or tail is not exactly one-hot, or when count is inconsistent with the pointers (head == tail while 0 < count < DEPTH).
  - Cleared only by reset.

## Timing
- Reset values: head = tail = 1 (bit 0), count_o = 0, empty_o = 1, full_o = 0, ptrErr_o = 0.
- During reset, enqReady_o, deqValid_o and ramWrEn_o are 0, because the RAM holds ramReady_i low.
- Reset asserted mid-operation:
  - At the next edge all state returns to reset values.
  - In-flight requests are lost.
- Write-to-read: an enqueue at edge N is readable at the head from cycle N+1 if the queue was empty.
- Dequeue takes effect at the edge. The head data is valid in the same cycle as deqValid_o; there is no registered read latency.
- Throughput: one enqueue and one dequeue per cycle, sustained whenever the queue is neither full nor empty.

## Structure
- Package onehot_queue_pkg holds:
  - the rotl1 function (rotate left by one),
  - the is_onehot function,
  - the CNT_W derivation.
- Sub-module onehot_ptr: DEPTH-bit rotating register with inputs advance_i and clear_i. It is instantiated twice, once for head and once for tail.
- Count register, flags and error checker live in the top module.

## Test plan
- DEPTH=4 reset then 4 enqueues (A,B,C,D):
  - ramWrAddr_o steps 0001, 0010, 0100, 1000.
  - count_o reaches 4, full_o=1, enqReady_o=0.
- Full queue with enq_i=1 and deq_i=1 simultaneously:
  - Only the dequeue is accepted; count_o goes 4→3 and ramWrEn_o=0.
  - ramRdAddr_o moves 0001→0010.
- Wrap-around:
  - After 6 enqueues and 6 interleaved dequeues, both pointers equal 0100 and count_o=0.
  - Read data order matches enqueue order.
- Flush with count_o=3 and enq_i=1:
  - Next cycle head = tail = 0001, count_o=0, empty_o=1.
  - No write occurred in the flush cycle.
- Empty queue with deq_i=1:
  - deqValid_o=0 and head is unchanged.
  - An enqueue in the same cycle gives count_o=1 next cycle.
- Reset asserted with count_o=2:
  - All outputs return to reset values at the next edge.
  - ramReady_i=0 keeps enqReady_o=0 until reset is released.

Source files
------------

// File: rtl/onehot_queue_pkg.sv
// Shared helpers for the one-hot queue controller: pointer rotation,
// one-hot validation and occupancy-count width derivation.
package onehot_queue_pkg;

  localparam int unsigned MAX_DEPTH = 64;

  typedef logic [MAX_DEPTH-1:0] ptr_vec_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Rotate the low `depth` bits left by one; bit depth-1 wraps to bit 0.
  function automatic ptr_vec_t rotl1(input ptr_vec_t v, input int unsigned depth);
    ptr_vec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (i < depth) begin
        r[i] = (i == 0) ? v[depth-1] : v[i-1];
      end
    end
    return r;
  endfunction

  function automatic logic is_onehot(input ptr_vec_t v);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      ones += 32'(v[i]);
    end
    return ones == 1;
  endfunction

endpackage

// File: rtl/onehot_queue_ctrl_if.sv
// Enqueue/dequeue/RAM-address bundle between the queue owner and the controller.
interface onehot_queue_ctrl_if
  import onehot_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = cnt_width(DEPTH)
);

  logic             ramReady_i;
  logic             flush_i;
  logic             enq_i;
  logic [WIDTH-1:0] enqData_i;
  logic             enqReady_o;
  logic             deq_i;
  logic             deqValid_o;
  logic [DEPTH-1:0] ramRdAddr_o;
  logic [DEPTH-1:0] ramWrAddr_o;
  logic [WIDTH-1:0] ramWrData_o;
  logic             ramWrEn_o;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;
  logic             ptrErr_o;

  modport master (
    output ramReady_i, flush_i, enq_i, enqData_i, deq_i,
    input  enqReady_o, deqValid_o, ramRdAddr_o, ramWrAddr_o, ramWrData_o,
           ramWrEn_o, count_o, full_o, empty_o, ptrErr_o
  );

  modport slave (
    input  ramReady_i, flush_i, enq_i, enqData_i, deq_i,
    output enqReady_o, deqValid_o, ramRdAddr_o, ramWrAddr_o, ramWrData_o,
           ramWrEn_o, count_o, full_o, empty_o, ptrErr_o
  );

endinterface

// File: rtl/onehot_ptr.sv
// Rotating one-hot pointer register; clear returns it to bit 0.
module onehot_ptr
  import onehot_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clkGated,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             clear_i,
  output logic [DEPTH-1:0] ptr_o
);

  localparam logic [DEPTH-1:0] PTR_INIT = DEPTH'(1);

  always_ff @(posedge clkGated) begin
    if (reset || clear_i) begin
      ptr_o <= PTR_INIT;
    end else if (advance_i) begin
      ptr_o <= DEPTH'(rotl1(MAX_DEPTH'(ptr_o), DEPTH));
    end
  end

endmodule

// File: rtl/onehot_queue_ctrl.sv
// FIFO controller producing one-hot read/write addresses for a decoder-less
// register RAM, with occupancy tracking and a sticky pointer-integrity flag.
module onehot_queue_ctrl
  import onehot_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic                clkGated,
  input logic                reset,
  onehot_queue_ctrl_if.slave q
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] headPtr;
  logic [DEPTH-1:0] tailPtr;
  logic [CNT_W-1:0] countQ;
  logic             ptrErrQ;
  logic             full;
  logic             empty;
  logic             enqReady;
  logic             deqValid;
  logic             enqAcc;
  logic             deqAcc;
  logic             errNow;

  assign full     = (countQ == CNT_FULL);
  assign empty    = (countQ == '0);
  assign enqReady = q.ramReady_i & ~full & ~q.flush_i;
  assign deqValid = q.ramReady_i & ~empty;
  assign enqAcc   = q.enq_i & enqReady;
  assign deqAcc   = q.deq_i & deqValid & ~q.flush_i;

  onehot_ptr #(.DEPTH(DEPTH)) u_head (
    .clkGated  (clkGated),
    .reset     (reset),
    .advance_i (deqAcc),
    .clear_i   (q.flush_i),
    .ptr_o     (headPtr)
  );

  onehot_ptr #(.DEPTH(DEPTH)) u_tail (
    .clkGated  (clkGated),
    .reset     (reset),
    .advance_i (enqAcc),
    .clear_i   (q.flush_i),
    .ptr_o     (tailPtr)
  );

  // Simultaneous enqueue and dequeue leave occupancy unchanged.
  always_ff @(posedge clkGated) begin
    if (reset || q.flush_i) begin
      countQ <= '0;
    end else if (enqAcc && !deqAcc) begin
      countQ <= countQ + CNT_W'(1);
    end else if (deqAcc && !enqAcc) begin
      countQ <= countQ - CNT_W'(1);
    end
  end

  // Equal pointers are only legal for an empty or full queue.
  assign errNow = !is_onehot(MAX_DEPTH'(headPtr)) || !is_onehot(MAX_DEPTH'(tailPtr)) ||
                  ((headPtr == tailPtr) && !empty && !full);

  always_ff @(posedge clkGated) begin
    if (reset) begin
      ptrErrQ <= 1'b0;
    end else if (errNow) begin
      ptrErrQ <= 1'b1;
    end
  end

  assign q.enqReady_o  = enqReady;
  assign q.deqValid_o  = deqValid;
  assign q.ramRdAddr_o = headPtr;
  assign q.ramWrAddr_o = tailPtr;
  assign q.ramWrData_o = q.enqData_i;
  assign q.ramWrEn_o   = enqAcc;
  assign q.count_o     = countQ;
  assign q.full_o      = full;
  assign q.empty_o     = empty;
  assign q.ptrErr_o    = ptrErrQ;

endmodule

// File: tb/tb_onehot_queue_ctrl.sv
// Directed bench for onehot_queue_ctrl at DEPTH=4 with a behavioural RAM.
module tb_onehot_queue_ctrl;

  logic clkGated;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] mem [4];

  onehot_queue_ctrl_if #(.DEPTH(4), .WIDTH(32)) q ();

  onehot_queue_ctrl #(.DEPTH(4)) dut (
    .clkGated (clkGated),
    .reset    (reset),
    .q        (q.slave)
  );

  initial clkGated = 1'b0;
  always #5 clkGated = ~clkGated;

  always @(posedge clkGated) begin
    if (q.ramWrEn_o) begin
      for (int i = 0; i < 4; i++) begin
        if (q.ramWrAddr_o[i]) mem[i] <= q.ramWrData_o;
      end
    end
  end

  function automatic logic [31:0] rd_data(input logic [3:0] addr);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      if (addr[i]) d = mem[i];
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clkGated);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; q.ramReady_i = 1'b0; q.flush_i = 1'b0;
    q.enq_i = 1'b1; q.enqData_i = 32'hDEAD_0000; q.deq_i = 1'b1;
    tick(); tick(); #1;
    total++; if (q.ramRdAddr_o !== 4'b0001) begin bad++; $display("FAIL reset_head got=%b exp=0001", q.ramRdAddr_o); end
    total++; if (q.ramWrAddr_o !== 4'b0001) begin bad++; $display("FAIL reset_tail got=%b exp=0001", q.ramWrAddr_o); end
    total++; if (q.count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", q.count_o); end
    total++; if (q.empty_o !== 1'b1 || q.full_o !== 1'b0) begin bad++; $display("FAIL reset_flags got=e%b f%b exp=e1 f0", q.empty_o, q.full_o); end
    total++; if (q.ptrErr_o !== 1'b0) begin bad++; $display("FAIL reset_ptrerr got=%b exp=0", q.ptrErr_o); end
    total++; if (q.enqReady_o !== 1'b0 || q.deqValid_o !== 1'b0 || q.ramWrEn_o !== 1'b0) begin
      bad++; $display("FAIL reset_hs got=r%b v%b w%b exp=0 0 0", q.enqReady_o, q.deqValid_o, q.ramWrEn_o); end
    reset = 1'b0; q.enq_i = 1'b0; q.deq_i = 1'b0; q.ramReady_i = 1'b1;
    tick();
  endtask

  task automatic test_fill(input logic [31:0] vals [4]);
    for (int i = 0; i < 4; i++) begin
      q.enq_i = 1'b1; q.enqData_i = vals[i]; #1;
      total++; if (q.ramWrAddr_o !== 4'(1 << i) || q.ramWrEn_o !== 1'b1) begin
        bad++; $display("FAIL fill_wraddr[%0d] got=%b en=%b exp=%b en=1", i, q.ramWrAddr_o, q.ramWrEn_o, 4'(1 << i)); end
      tick();
    end
    q.enq_i = 1'b0; #1;
    total++; if (q.count_o !== 3'd4 || q.full_o !== 1'b1 || q.empty_o !== 1'b0) begin
      bad++; $display("FAIL fill_count got=%0d f%b e%b exp=4 f1 e0", q.count_o, q.full_o, q.empty_o); end
    total++; if (q.enqReady_o !== 1'b0 || q.deqValid_o !== 1'b1) begin
      bad++; $display("FAIL fill_hs got=r%b v%b exp=r0 v1", q.enqReady_o, q.deqValid_o); end
  endtask

  task automatic test_full_enq_deq(input logic [31:0] vals [4]);
    q.enq_i = 1'b1; q.enqData_i = 32'hEEEE_EEEE; q.deq_i = 1'b1; #1;
    total++; if (q.ramWrEn_o !== 1'b0) begin bad++; $display("FAIL full_wren got=%b exp=0", q.ramWrEn_o); end
    total++; if (rd_data(q.ramRdAddr_o) !== vals[0]) begin bad++; $display("FAIL full_rd got=%h exp=%h", rd_data(q.ramRdAddr_o), vals[0]); end
    tick();
    q.enq_i = 1'b0; q.deq_i = 1'b0; #1;
    total++; if (q.count_o !== 3'd3 || q.ramRdAddr_o !== 4'b0010 || q.ramWrAddr_o !== 4'b0001) begin
      bad++; $display("FAIL full_after got=c%0d h%b t%b exp=c3 h0010 t0001", q.count_o, q.ramRdAddr_o, q.ramWrAddr_o); end
    for (int i = 1; i < 4; i++) begin
      q.deq_i = 1'b1; #1;
      total++; if (rd_data(q.ramRdAddr_o) !== vals[i]) begin bad++; $display("FAIL drain_rd[%0d] got=%h exp=%h", i, rd_data(q.ramRdAddr_o), vals[i]); end
      tick();
    end
    q.deq_i = 1'b0; #1;
    total++; if (q.count_o !== 3'd0 || q.empty_o !== 1'b1 || q.ramRdAddr_o !== 4'b0001) begin
      bad++; $display("FAIL drain_end got=c%0d e%b h%b exp=c0 e1 h0001", q.count_o, q.empty_o, q.ramRdAddr_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] w [6];
    w = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004, 32'h6666_0005};
    q.enq_i = 1'b1; q.enqData_i = w[0];
    tick();
    for (int i = 1; i < 6; i++) begin
      q.enq_i = 1'b1; q.enqData_i = w[i]; q.deq_i = 1'b1; #1;
      total++; if (rd_data(q.ramRdAddr_o) !== w[i-1] || q.count_o !== 3'd1 || q.ramWrEn_o !== 1'b1) begin
        bad++; $display("FAIL wrap_rd[%0d] got=%h c%0d w%b exp=%h c1 w1", i, rd_data(q.ramRdAddr_o), q.count_o, q.ramWrEn_o, w[i-1]); end
      tick();
    end
    q.enq_i = 1'b0; q.deq_i = 1'b1; #1;
    total++; if (rd_data(q.ramRdAddr_o) !== w[5]) begin bad++; $display("FAIL wrap_last got=%h exp=%h", rd_data(q.ramRdAddr_o), w[5]); end
    tick();
    q.deq_i = 1'b0; #1;
    total++; if (q.ramRdAddr_o !== 4'b0100 || q.ramWrAddr_o !== 4'b0100 || q.count_o !== 3'd0 || q.empty_o !== 1'b1) begin
      bad++; $display("FAIL wrap_end got=h%b t%b c%0d e%b exp=h0100 t0100 c0 e1", q.ramRdAddr_o, q.ramWrAddr_o, q.count_o, q.empty_o); end
  endtask

  task automatic test_flush();
    logic [31:0] saved;
    for (int i = 0; i < 3; i++) begin
      q.enq_i = 1'b1; q.enqData_i = 32'hF0F0_0000 + 32'(i);
      tick();
    end
    q.enq_i = 1'b0; #1;
    total++; if (q.count_o !== 3'd3 || q.ramWrAddr_o !== 4'b0010) begin
      bad++; $display("FAIL flush_pre got=c%0d t%b exp=c3 t0010", q.count_o, q.ramWrAddr_o); end
    saved = mem[1];
    q.flush_i = 1'b1; q.enq_i = 1'b1; q.enqData_i = 32'hF1F1_F1F1; q.deq_i = 1'b1; #1;
    total++; if (q.ramWrEn_o !== 1'b0 || q.enqReady_o !== 1'b0) begin
      bad++; $display("FAIL flush_hs got=w%b r%b exp=w0 r0", q.ramWrEn_o, q.enqReady_o); end
    tick();
    q.flush_i = 1'b0; q.enq_i = 1'b0; q.deq_i = 1'b0; #1;
    total++; if (q.ramRdAddr_o !== 4'b0001 || q.ramWrAddr_o !== 4'b0001 || q.count_o !== 3'd0 || q.empty_o !== 1'b1) begin
      bad++; $display("FAIL flush_post got=h%b t%b c%0d e%b exp=h0001 t0001 c0 e1", q.ramRdAddr_o, q.ramWrAddr_o, q.count_o, q.empty_o); end
    total++; if (mem[1] !== saved) begin bad++; $display("FAIL flush_nowrite got=%h exp=%h", mem[1], saved); end
  endtask

  task automatic test_empty_deq();
    q.deq_i = 1'b1; q.enq_i = 1'b1; q.enqData_i = 32'h6060_6060; #1;
    total++; if (q.deqValid_o !== 1'b0 || q.ramWrEn_o !== 1'b1) begin
      bad++; $display("FAIL empty_hs got=v%b w%b exp=v0 w1", q.deqValid_o, q.ramWrEn_o); end
    tick();
    q.deq_i = 1'b0; q.enq_i = 1'b0; #1;
    total++; if (q.ramRdAddr_o !== 4'b0001 || q.ramWrAddr_o !== 4'b0010 || q.count_o !== 3'd1) begin
      bad++; $display("FAIL empty_post got=h%b t%b c%0d exp=h0001 t0010 c1", q.ramRdAddr_o, q.ramWrAddr_o, q.count_o); end
    total++; if (q.deqValid_o !== 1'b1 || rd_data(q.ramRdAddr_o) !== 32'h6060_6060) begin
      bad++; $display("FAIL empty_rd got=v%b d%h exp=v1 d60606060", q.deqValid_o, rd_data(q.ramRdAddr_o)); end
  endtask

  task automatic test_reset_mid();
    q.enq_i = 1'b1; q.enqData_i = 32'h7070_7070;
    tick();
    q.enq_i = 1'b0; #1;
    total++; if (q.count_o !== 3'd2) begin bad++; $display("FAIL mid_pre got=%0d exp=2", q.count_o); end
    reset = 1'b1; q.ramReady_i = 1'b0; q.enq_i = 1'b1; q.deq_i = 1'b1; #1;
    total++; if (q.enqReady_o !== 1'b0 || q.ramWrEn_o !== 1'b0 || q.deqValid_o !== 1'b0) begin
      bad++; $display("FAIL mid_hs got=r%b w%b v%b exp=0 0 0", q.enqReady_o, q.ramWrEn_o, q.deqValid_o); end
    tick();
    total++; if (q.ramRdAddr_o !== 4'b0001 || q.ramWrAddr_o !== 4'b0001 || q.count_o !== 3'd0 ||
                 q.empty_o !== 1'b1 || q.full_o !== 1'b0 || q.ptrErr_o !== 1'b0) begin
      bad++; $display("FAIL mid_post got=h%b t%b c%0d e%b f%b x%b exp=h0001 t0001 c0 e1 f0 x0",
                      q.ramRdAddr_o, q.ramWrAddr_o, q.count_o, q.empty_o, q.full_o, q.ptrErr_o); end
    tick();
    reset = 1'b0; q.enq_i = 1'b0; q.deq_i = 1'b0; #1;
    total++; if (q.enqReady_o !== 1'b0) begin bad++; $display("FAIL mid_notready got=%b exp=0", q.enqReady_o); end
    tick();
    q.ramReady_i = 1'b1; #1;
    total++; if (q.enqReady_o !== 1'b1 || q.count_o !== 3'd0) begin
      bad++; $display("FAIL mid_ready got=r%b c%0d exp=r1 c0", q.enqReady_o, q.count_o); end
  endtask

  initial begin
    logic [31:0] vals [4];
    total = 0;
    bad = 0;
    vals = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    test_reset();
    test_fill(vals);
    test_full_enq_deq(vals);
    test_wrap();
    test_flush();
    test_empty_deq();
    test_reset_mid();
    total++; if (q.ptrErr_o !== 1'b0) begin bad++; $display("FAIL final_ptrerr got=%b exp=0", q.ptrErr_o); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
